// File: rtl/uartb_mem_dump_if.sv
// Bus bundle for the UART memory readback engine: host control, memory read
// port, baud tick and the serial line. The engine takes the slave view; the
// surrounding system (or a bench) takes the master view.
interface uartb_mem_dump_if #(
  parameter int ADDR_W = 16,
  parameter int CNT_W  = 16
);
  logic              s_tick;
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic [CNT_W-1:0]  word_cnt;
  logic              mem_rd;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_rdata;
  logic              tx;
  logic              busy;
  logic              done_tick;

  modport slave (
    input  s_tick, start, base_addr, word_cnt, mem_rdata,
    output mem_rd, mem_addr, tx, busy, done_tick
  );

  modport master (
    output s_tick, start, base_addr, word_cnt, mem_rdata,
    input  mem_rd, mem_addr, tx, busy, done_tick
  );
endinterface

// File: rtl/uartb_mem_dump.sv
// UART memory readback engine. On start it sends a header byte, then every
// word of the requested block little-endian, then an 8-bit sum of the data
// bytes, all through an internal 8N1 serializer paced by a 16x baud tick.
module uartb_mem_dump #(
  parameter int         SB_TICK  = 16,
  parameter int         ADDR_W   = 16,
  parameter int         CNT_W    = 16,
  parameter logic [7:0] HDR_BYTE = 8'hA5
) (
  input logic             clk,
  input logic             rst,
  uartb_mem_dump_if.slave bus
);

  // Last tick index of the stop bit; the tick counter is only 4 bits wide.
  localparam logic [3:0] SB_LAST = 4'(SB_TICK - 1);

  typedef enum logic [2:0] {
    C_IDLE,
    C_HDR,
    C_FETCH,
    C_WAIT,
    C_SEND,
    C_CSUM,
    C_FLUSH
  } ctrl_state_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } ser_state_t;

  // Controller state
  ctrl_state_t       ctrl_state;
  logic [ADDR_W-1:0] addr_reg;
  logic [CNT_W-1:0]  remaining_reg;
  logic [7:0]        csum_reg;
  logic [31:0]       word_buf_reg;
  logic [1:0]        byte_idx_reg;
  logic              mem_rd_reg;
  logic [ADDR_W-1:0] mem_addr_reg;
  logic              busy_reg;
  logic              done_tick_reg;

  // Hand-off from controller to serializer: a one-cycle load strobe + byte
  logic              load_reg;
  logic [7:0]        load_byte_reg;

  // Serializer state
  ser_state_t        ser_state;
  logic [3:0]        tick_cnt_reg;
  logic [2:0]        bit_cnt_reg;
  logic [7:0]        shift_reg;
  logic              tx_reg;

  logic              ser_ready;
  logic              stop_last;
  logic [7:0]        word_bytes [4];
  logic [7:0]        cur_byte;

  // Split the buffered word into its four byte lanes, lane 0 = bits [7:0].
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign word_bytes[gi] = word_buf_reg[8*gi +: 8];
  end

  // The serializer only accepts a byte when idle and no load is in flight;
  // the load strobe is registered, so it also blocks the cycle it is high.
  assign ser_ready = (ser_state == S_IDLE) && !load_reg;

  // Final tick of a stop bit: the frame completes at the following edge.
  assign stop_last = (ser_state == S_STOP) && bus.s_tick && (tick_cnt_reg == SB_LAST);

  // Byte currently selected from the word buffer.
  always_comb begin
    cur_byte = word_bytes[byte_idx_reg];
  end

  // Controller: sequences header, word fetches, data bytes and checksum.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl_state    <= C_IDLE;
      addr_reg      <= '0;
      remaining_reg <= '0;
      csum_reg      <= 8'h00;
      word_buf_reg  <= 32'h0;
      byte_idx_reg  <= 2'd0;
      mem_rd_reg    <= 1'b0;
      mem_addr_reg  <= '0;
      busy_reg      <= 1'b0;
      done_tick_reg <= 1'b0;
      load_reg      <= 1'b0;
      load_byte_reg <= 8'h00;
    end else begin
      load_reg      <= 1'b0;
      done_tick_reg <= 1'b0;
      case (ctrl_state)
        C_IDLE: begin
          if (bus.start) begin
            addr_reg      <= bus.base_addr;
            remaining_reg <= bus.word_cnt;
            csum_reg      <= 8'h00;
            busy_reg      <= 1'b1;
            ctrl_state    <= C_HDR;
          end
        end
        C_HDR: begin
          // The serializer is always idle here: the previous dump ended on
          // the same edge that returned it to its idle state.
          load_reg      <= 1'b1;
          load_byte_reg <= HDR_BYTE;
          if (remaining_reg == '0) begin
            ctrl_state <= C_CSUM;
          end else begin
            mem_rd_reg   <= 1'b1;
            mem_addr_reg <= addr_reg;
            ctrl_state   <= C_FETCH;
          end
        end
        C_FETCH: begin
          // Read strobe was raised on entry; it lasts exactly this cycle.
          mem_rd_reg <= 1'b0;
          ctrl_state <= C_WAIT;
        end
        C_WAIT: begin
          word_buf_reg <= bus.mem_rdata;
          byte_idx_reg <= 2'd0;
          ctrl_state   <= C_SEND;
        end
        C_SEND: begin
          if (ser_ready) begin
            load_reg      <= 1'b1;
            load_byte_reg <= cur_byte;
            csum_reg      <= csum_reg + cur_byte;
            if (byte_idx_reg == 2'd3) begin
              addr_reg      <= addr_reg + ADDR_W'(1);
              remaining_reg <= remaining_reg - CNT_W'(1);
              if (remaining_reg != CNT_W'(1)) begin
                // Prefetch the next word while byte 3 is on the wire.
                mem_rd_reg   <= 1'b1;
                mem_addr_reg <= addr_reg + ADDR_W'(1);
                ctrl_state   <= C_FETCH;
              end else begin
                ctrl_state <= C_CSUM;
              end
            end else begin
              byte_idx_reg <= byte_idx_reg + 2'd1;
            end
          end
        end
        C_CSUM: begin
          if (ser_ready) begin
            load_reg      <= 1'b1;
            load_byte_reg <= csum_reg;
            ctrl_state    <= C_FLUSH;
          end
        end
        C_FLUSH: begin
          if (stop_last) begin
            done_tick_reg <= 1'b1;
            busy_reg      <= 1'b0;
            ctrl_state    <= C_IDLE;
          end
        end
        default: begin
          ctrl_state <= C_IDLE;
        end
      endcase
    end
  end

  // Serializer: 8N1 framing, 16 ticks per start/data bit, SB_TICK for stop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ser_state    <= S_IDLE;
      tick_cnt_reg <= 4'd0;
      bit_cnt_reg  <= 3'd0;
      shift_reg    <= 8'h00;
      tx_reg       <= 1'b1;
    end else begin
      case (ser_state)
        S_IDLE: begin
          if (load_reg) begin
            shift_reg    <= load_byte_reg;
            tick_cnt_reg <= 4'd0;
            bit_cnt_reg  <= 3'd0;
            tx_reg       <= 1'b0;
            ser_state    <= S_START;
          end
        end
        S_START: begin
          if (bus.s_tick) begin
            if (tick_cnt_reg == 4'd15) begin
              tick_cnt_reg <= 4'd0;
              tx_reg       <= shift_reg[0];
              ser_state    <= S_DATA;
            end else begin
              tick_cnt_reg <= tick_cnt_reg + 4'd1;
            end
          end
        end
        S_DATA: begin
          if (bus.s_tick) begin
            if (tick_cnt_reg == 4'd15) begin
              tick_cnt_reg <= 4'd0;
              if (bit_cnt_reg == 3'd7) begin
                tx_reg    <= 1'b1;
                ser_state <= S_STOP;
              end else begin
                bit_cnt_reg <= bit_cnt_reg + 3'd1;
                shift_reg   <= {1'b0, shift_reg[7:1]};
                tx_reg      <= shift_reg[1];
              end
            end else begin
              tick_cnt_reg <= tick_cnt_reg + 4'd1;
            end
          end
        end
        S_STOP: begin
          if (bus.s_tick) begin
            if (tick_cnt_reg == SB_LAST) begin
              tick_cnt_reg <= 4'd0;
              ser_state    <= S_IDLE;
            end else begin
              tick_cnt_reg <= tick_cnt_reg + 4'd1;
            end
          end
        end
        default: begin
          ser_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.tx        = tx_reg;
  assign bus.busy      = busy_reg;
  assign bus.done_tick = done_tick_reg;
  assign bus.mem_rd    = mem_rd_reg;
  assign bus.mem_addr  = mem_addr_reg;

endmodule

// File: tb/tb_uartb_mem_dump.sv
// Bench for uartb_mem_dump: a frame-level UART receiver plus a dump model
// predict every byte, fetch address, busy level and done pulse; directed
// dumps add literal expectations on top.
`timescale 1ns/1ps
module tb_uartb_mem_dump;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic clk_en = 1'b1;

  uartb_mem_dump_if #(.ADDR_W(16), .CNT_W(16)) bus();

  uartb_mem_dump #(
    .SB_TICK(16), .ADDR_W(16), .CNT_W(16), .HDR_BYTE(8'hA5)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // Clock can be frozen (low) by clearing clk_en.
  always #5 if (clk_en) clk = ~clk;

  // 16x baud tick: one pulse every 3 clk cycles.
  logic [1:0] tdiv = 2'd0;
  always @(posedge clk) begin
    tdiv       <= (tdiv == 2'd2) ? 2'd0 : tdiv + 2'd1;
    bus.s_tick <= (tdiv == 2'd2);
  end

  // Synchronous-read memory, data valid the cycle after mem_rd.
  logic [31:0] mem [0:65535];
  always @(posedge clk) begin
    if (bus.mem_rd) bus.mem_rdata <= mem[bus.mem_addr];
  end

  int errors = 0;
  int checks = 0;

  // Model / receiver state
  logic [7:0]  exp_bytes[$];
  logic [15:0] exp_addrs[$];
  logic [7:0]  rx_log[$];
  logic [15:0] addr_log[$];
  bit          m_busy;
  longint      cyc = 0;
  longint      exp_done;
  longint      end_cyc;
  longint      acc_cyc;
  bit          gap_armed;
  bit          hdr_armed;
  bit          in_frame;
  bit          shape_ok;
  logic        lvl;
  int          rtk;
  logic [7:0]  rbyte;
  int          frames_rx = 0;
  int          dumps_done = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic model_clear();
    exp_bytes.delete();
    exp_addrs.delete();
    m_busy    = 1'b0;
    exp_done  = -1;
    gap_armed = 1'b0;
    hdr_armed = 1'b0;
    in_frame  = 1'b0;
  endtask

  // One negedge step of the model: compare outputs, decode tx, track starts.
  task automatic monitor_step();
    logic [7:0]  eb;
    logic [7:0]  sum;
    logic [15:0] a;
    logic [31:0] w;
    int          ph;
    int          pos;
    cyc++;
    if (rst) begin
      model_clear();
      return;
    end
    if (exp_done == cyc) m_busy = 1'b0;
    chk("busy", bus.busy, m_busy);
    if (bus.done_tick || exp_done == cyc) begin
      chk("done_tick", bus.done_tick, exp_done == cyc);
      if (exp_done == cyc) begin
        dumps_done++;
        chk("fetches_left", exp_addrs.size(), 0);
        $display("dump %0d complete: %0d frames received", dumps_done, rx_log.size());
      end
    end
    if (bus.mem_rd) begin
      addr_log.push_back(bus.mem_addr);
      if (exp_addrs.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL mem_rd_unexpected actual addr=%0h required=no read", bus.mem_addr);
      end else begin
        chk("mem_addr", bus.mem_addr, exp_addrs.pop_front());
      end
    end
    // UART receiver
    if (!in_frame && !bus.tx) begin
      in_frame = 1'b1;
      rtk      = 0;
      shape_ok = 1'b1;
      if (gap_armed) chk("gap_le3", (cyc - end_cyc) <= 3, 1);
      if (hdr_armed) chk("hdr_latency", (cyc - acc_cyc) <= 3, 1);
      gap_armed = 1'b0;
      hdr_armed = 1'b0;
    end
    if (in_frame && bus.s_tick) begin
      rtk++;
      ph  = (rtk - 1) % 16;
      pos = (rtk - 1) / 16;
      if (ph == 0) lvl = bus.tx;
      else if (bus.tx !== lvl) shape_ok = 1'b0;
      if (pos == 0 && bus.tx) shape_ok = 1'b0;
      if (pos == 9 && !bus.tx) shape_ok = 1'b0;
      if (ph == 7 && pos >= 1 && pos <= 8) rbyte[pos-1] = bus.tx;
      if (rtk == 160) begin
        in_frame = 1'b0;
        frames_rx++;
        rx_log.push_back(rbyte);
        chk("frame_shape", shape_ok, 1);
        if (exp_bytes.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL frame_unexpected actual byte=%0h required=no frame", rbyte);
        end else begin
          eb = exp_bytes.pop_front();
          chk("frame_byte", rbyte, eb);
          if (exp_bytes.size() == 0) begin
            exp_done = cyc + 1;
          end else begin
            gap_armed = 1'b1;
            end_cyc   = cyc;
          end
        end
      end
    end
    // Start acceptance: build the whole expected dump from the inputs.
    if (bus.start && !m_busy) begin
      m_busy    = 1'b1;
      hdr_armed = 1'b1;
      acc_cyc   = cyc;
      sum       = 8'h00;
      exp_bytes.push_back(8'hA5);
      for (int i = 0; i < int'(bus.word_cnt); i++) begin
        a = bus.base_addr + 16'(i);
        w = mem[a];
        exp_addrs.push_back(a);
        for (int k = 0; k < 4; k++) begin
          exp_bytes.push_back(w[8*k +: 8]);
          sum = sum + w[8*k +: 8];
        end
      end
      exp_bytes.push_back(sum);
    end
  endtask

  task automatic wait_dump(input int d0);
    for (int i = 0; i < 30000 && dumps_done == d0; i++) @(posedge clk);
    chk("dump_finished", dumps_done != d0, 1);
    repeat (30) @(posedge clk);
    chk("single_done", dumps_done - d0, 1);
  endtask

  task automatic run_dump(input logic [15:0] b, input logic [15:0] n, input bit pester);
    int d0;
    d0 = dumps_done;
    rx_log.delete();
    addr_log.delete();
    @(posedge clk); #1;
    bus.base_addr = b;
    bus.word_cnt  = n;
    bus.start     = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    if (pester) begin
      for (int p = 0; p < 6; p++) begin
        repeat (97) @(posedge clk);
        #1;
        bus.base_addr = b + 16'h0100;
        bus.word_cnt  = n + 16'd3;
        bus.start     = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
      end
    end
    wait_dump(d0);
  endtask

  logic [7:0] exp1 [6];
  logic [7:0] exp5 [6];

  initial begin
    bus.start     = 1'b0;
    bus.base_addr = 16'h0;
    bus.word_cnt  = 16'h0;
    model_clear();
    exp1 = '{8'hA5, 8'h44, 8'h33, 8'h22, 8'h11, 8'hAA};
    exp5 = '{8'hA5, 8'h33, 8'h00, 8'hAA, 8'h55, 8'h32};
    mem[16'h0010] = 32'h11223344;
    mem[16'hFFFF] = 32'hFFFFFFFF;
    mem[16'h0000] = 32'hFFFFFFFF;
    mem[16'h0020] = 32'hDEADBEEF;
    mem[16'h0021] = 32'h01020304;
    mem[16'h0030] = 32'h55AA0033;

    fork
      forever begin
        @(negedge clk);
        monitor_step();
      end
    join_none

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tx", bus.tx, 1);
    chk("rst_busy", bus.busy, 0);
    chk("rst_mem_rd", bus.mem_rd, 0);
    chk("rst_done", bus.done_tick, 0);
    chk("rst_mem_addr", bus.mem_addr, 0);
    rst = 1'b0;
    repeat (200) @(posedge clk);
    #1;
    chk("idle_frames", frames_rx, 0);
    chk("idle_tx", bus.tx, 1);

    // Empty dump
    run_dump(16'h0040, 16'd0, 1'b0);
    chk("empty_len", rx_log.size(), 2);
    chk("empty_hdr", rx_log[0], 8'hA5);
    chk("empty_csum", rx_log[1], 8'h00);
    chk("empty_reads", addr_log.size(), 0);

    // Single word
    run_dump(16'h0010, 16'd1, 1'b0);
    chk("one_len", rx_log.size(), 6);
    for (int i = 0; i < 6; i++) chk("one_byte", rx_log[i], exp1[i]);
    chk("one_reads", addr_log.size(), 1);
    chk("one_addr", addr_log[0], 16'h0010);

    // Address wrap, all-ones data
    run_dump(16'hFFFF, 16'd2, 1'b0);
    chk("wrap_len", rx_log.size(), 10);
    chk("wrap_addr0", addr_log[0], 16'hFFFF);
    chk("wrap_addr1", addr_log[1], 16'h0000);
    chk("wrap_csum", rx_log[9], 8'hF8);

    // Start pulses during a dump are ignored
    run_dump(16'h0020, 16'd2, 1'b1);
    chk("pester_len", rx_log.size(), 10);
    chk("pester_reads", addr_log.size(), 2);
    chk("pester_addr1", addr_log[1], 16'h0021);

    // Reset during data bits of the third frame, clock frozen
    begin
      int f0;
      f0 = frames_rx;
      rx_log.delete();
      addr_log.delete();
      @(posedge clk); #1;
      bus.base_addr = 16'h0030;
      bus.word_cnt  = 16'd1;
      bus.start     = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      for (int i = 0; i < 5000 && frames_rx < f0 + 2; i++) @(posedge clk);
      chk("two_frames_seen", frames_rx - f0, 2);
      for (int i = 0; i < 50 && bus.tx; i++) @(posedge clk);
      repeat (168) @(posedge clk);
      @(negedge clk); #1;
      clk_en = 1'b0;
      chk("pre_rst_tx", bus.tx, 0);
      rst = 1'b1;
      #1;
      chk("async_tx", bus.tx, 1);
      chk("async_busy", bus.busy, 0);
      chk("async_mem_rd", bus.mem_rd, 0);
      #50;
      chk("held_tx", bus.tx, 1);
      model_clear();
      rst = 1'b0;
      #2;
      clk_en = 1'b1;
      f0 = frames_rx;
      repeat (400) @(posedge clk);
      #1;
      chk("post_rst_frames", frames_rx - f0, 0);
      chk("post_rst_tx", bus.tx, 1);
      chk("post_rst_busy", bus.busy, 0);
    end

    run_dump(16'h0030, 16'd1, 1'b0);
    chk("redo_len", rx_log.size(), 6);
    for (int i = 0; i < 6; i++) chk("redo_byte", rx_log[i], exp5[i]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uartb_mem_dump.md
# uartb_mem_dump

UART memory readback engine for the bootloader: on a start pulse it reads a block of 32-bit words from a synchronous-read memory port and serializes them over the UART TX line. The frame is a header byte, the data bytes little-endian, then an 8-bit checksum. It is the reader counterpart to the bootloader's UART-to-memory write path, so the host can verify an image after download. It contains its own 8N1 serializer driven by the shared 16x oversampling baud tick.

## Interface
- SB_TICK, 16, ticks (of s_tick) for the stop bit
- ADDR_W, 16, word-address width
- CNT_W, 16, word-count width
- HDR_BYTE, 8'hA5, header byte sent before data
- clk  input  1  system clock, single clock domain
- rst  input  1  asynchronous, active-high reset
- s_tick  input  1  16x baud tick, one clk cycle wide
- start  input  1  pulse: begin dump; sampled only when busy=0
- base_addr  input  ADDR_W  first word address, captured on accepted start
- word_cnt  input  CNT_W  number of words to send, captured on accepted start
- mem_rd  output  1  one-cycle memory read strobe
- mem_addr  output  ADDR_W  word address, valid while mem_rd=1
- mem_rdata  input  32  read data, valid exactly 1 clk after mem_rd
- tx  output  1  UART serial out, idle high
- busy  output  1  dump in progress
- done_tick  output  1  one-cycle pulse when the final stop bit completes

## Operation
- Controller FSM states:
  - IDLE: accepts start; captures addr and remaining count; clears checksum; goes to HDR.
  - HDR: hands HDR_BYTE to the serializer. If count=0, goes to CSUM; otherwise goes to FETCH.
  - FETCH: asserts mem_rd with mem_addr=addr for 1 cycle; goes to WAIT.
  - WAIT: latches mem_rdata into the word buffer; byte index=0; goes to SEND.
  - SEND: when the serializer is ready, hands byte[index], taking bits [8i+7:8i]. Adds the byte to the checksum mod 256. On index 3: addr increments and count decrements. Goes to FETCH if count is still nonzero, else to CSUM.
  - CSUM: hands the checksum byte; goes to FLUSH.
  - FLUSH: waits for the serializer to finish the stop bit; pulses done_tick; goes to IDLE.
- Checksum covers data bytes only, not the header. An empty dump sends checksum 0x00.
- addr wraps modulo 2^ADDR_W.
- Serializer states IDLE/START/DATA/STOP:
  - Frame is 1 start bit (0, 16 ticks), 8 data bits LSB first (16 ticks each), and a stop bit (1, SB_TICK ticks).
  - Tick counter is 4 bits; bit counter is 3 bits.
  - Ready is asserted only in its IDLE state with no load pending.
- start asserted while busy=1 is ignored and does not queue.
- Simultaneous start and rst: rst wins.

## Timing
- Reset values: tx=1, busy=0, done_tick=0, mem_rd=0, mem_addr=0; both FSMs in IDLE; checksum=0.
- rst forces tx=1 immediately, with no clk edge needed, including mid-frame. The aborted frame is never resumed.
- busy=1 from the clk edge after start is accepted until the cycle done_tick pulses; busy=0 in the done_tick cycle.
- tx goes low (start bit of the header) within 2 clk cycles of start acceptance.
- Bit period = 16 s_tick pulses. tx changes only in the clk cycle after a qualifying s_tick, or on a frame load.
- Gap between the end of one stop bit and the next start bit is ≤ 3 clk cycles, including across a word fetch.
- A word fetch takes 2 cycles, FETCH then WAIT. Fetch is issued only after byte 3 of the previous word has been loaded.
- Total frame count per dump = 2 + 4·word_cnt.
- done_tick is asserted 1 clk after the final stop bit's last tick.

## Test plan
- Reset: hold rst mid-sim with clk stopped -> tx=1, busy=0, mem_rd=0 immediately. After release, no activity until start.
- word_cnt=0, start -> frames A5, 00; no mem_rd; one done_tick; busy drops.
- base_addr=0x0010, word_cnt=1, mem[0x10]=0x11223344:
  - one mem_rd with mem_addr=0x0010.
  - frames A5, 44, 33, 22, 11, AA.
  - each frame is 160 ticks, LSB first.
- word_cnt=2, both words 0xFFFFFFFF, base_addr=0xFFFF:
  - mem_addr sequence is 0xFFFF then 0x0000 (wrap).
  - checksum 0xF8.
  - inter-frame gap ≤ 3 clk cycles.
- Pulse start repeatedly during a dump -> no restart, no change to the captured base/count, exactly one done_tick.
- Assert rst during the DATA bits of the third frame -> tx=1 at once, busy=0. A fresh start afterward produces a complete, correct dump from the header.
